arm_regfile_sb: RTL and testbench
=================================

// Module: arm_regfile_sb
// PURPOSE
// - Parametrised ID-stage register file for the pipelined ARM core: N read ports, 1 write-back port.
// - Write-to-read bypass within the same cycle.
// - Per-register pending-write scoreboard, used by hazard detection to stall dependent instructions.
// - R15 (PC) is held outside this block; NUM_REGS covers R0..R14 by default.
// PARAMETERS
// - DATA_W    32  register width in bits
// - NUM_REGS  15  number of architectural registers held (2..2**ADDR_W)
// - ADDR_W    4   register address width
// - NUM_RD    2   number of read ports (1..4)
// - PEND_W    2   width of each pending-write counter (max in-flight writes per reg = 2**PEND_W-1)
// - INIT_IDX  1   reset contents: 1 -> reg[i]=i, 0 -> all zero
// PORTS
// - clk        in   1              clock; all state updates on posedge
// - rst        in   1              reset, asynchronous, active-high
// - rd_addr    in   NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
// - rd_data    out  NUM_RD*DATA_W  read data, combinational
// - rd_busy    out  NUM_RD         1 = addressed reg has a pending write (counter != 0)
// - iss_valid  in   1              issue stage dispatching an instruction that writes iss_dest
// - iss_dest   in   ADDR_W         destination of the issuing instruction
// - iss_ready  out  1              0 = iss_dest counter saturated; the issue must be held
// - wb_en      in   1              write-back enable
// - wb_addr    in   ADDR_W         write-back destination
// - wb_data    in   DATA_W         write-back data
// - flush      in   1              pipeline flush: clears all pending counters
// BEHAVIOUR
// - Reset (async): reg[i] = INIT_IDX ? i : 0; all counters = 0. Outputs follow combinationally from this state.
// - Write: on posedge, if wb_en && wb_addr < NUM_REGS, then reg[wb_addr] <= wb_data. Out-of-range writes are ignored.
// - Read: rd_data[k] = reg[rd_addr[k]].
//   - Bypass: if wb_en && wb_addr == rd_addr[k] && in range, rd_data[k] = wb_data (same cycle, 0 latency).
//   - rd_addr >= NUM_REGS gives rd_data = 0 and rd_busy = 0.
// - rd_busy[k] = (cnt[rd_addr[k]] != 0) && !(the only pending write is retiring this cycle, i.e. cnt==1 && wb match).
//   - The bypassed value is valid, so this case does not cause a stall.
// - Issue handshake:
//   - Issue accepted when iss_valid && iss_ready && iss_dest < NUM_REGS.
//   - iss_ready = (cnt[iss_dest] != max) || (wb retires iss_dest this cycle).
//   - iss_ready is 1 for out-of-range iss_dest; the counter is unaffected.
// - Counter update per register r, each posedge:
//   - inc = accepted issue to r; dec = wb_en to r with cnt[r] != 0.
//   - inc && !dec -> +1; dec && !inc -> -1; both -> unchanged.
//   - A write-back to r while cnt[r] == 0 still writes data; the counter stays 0 (no underflow).
// - flush: on posedge, all counters <= 0. flush has priority over the same-cycle issue.
//   - The same-cycle write-back still writes data.
// - rst asserted mid-operation: data and counters are reinitialised immediately.
//   - No write is performed while rst is high.
// - No read-port conflicts: any ports may address the same register.
// STRUCTURE
// - Shared package arm_pkg: REG_ADDR_W=4, ARM_DATA_W=32, ARM_NUM_GPR=15, the PC index constant 4'd15.
// - One sub-module, sb_counter: a PEND_W-bit up/down counter with inc, dec, clr, sat_o and zero_o.
//   - Instantiated NUM_REGS times via generate.
// - Read muxes and bypass compare are generated per read port.
// TESTING
// - Reset, INIT_IDX=1: read R0..R14 on ports 0/1 -> rd_data = 0..14; all rd_busy = 0; iss_ready = 1.
// - Write 0xDEADBEEF to R3 while reading R3 on port 1 -> same-cycle rd_data = 0xDEADBEEF; next cycle reg value = 0xDEADBEEF.
// - Issue R5, then R5 again -> cnt = 2, rd_busy = 1.
//   - Then wb R5 twice -> busy clears in the cycle of the second write-back (bypass), cnt = 0 after it.
// - Issue R7 three times (PEND_W=2) -> iss_ready = 0 on the 4th attempt; counter holds at 3.
//   - Issue + wb to R7 in the same cycle -> iss_ready = 1, cnt stays 3.
// - Issue R2, R4, then flush together with an issue to R9 -> all rd_busy = 0 next cycle, R9 not pending.
// - rst pulse mid-stream after writing R1 = 0x55 -> R1 reads 1 immediately and all counters read 0.
//   - Out-of-range wb_addr 15 -> no register changes.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM core constants: register-file geometry and the PC index.
package arm_pkg;

  localparam int REG_ADDR_W  = 4;
  localparam int ARM_DATA_W  = 32;
  localparam int ARM_NUM_GPR = 15;

  localparam logic [REG_ADDR_W-1:0] ARM_PC_IDX = 4'd15;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: counts issued-but-not-retired writes.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt_o,
  output logic         sat_o,
  output logic         zero_o
);

  logic [W-1:0] r_cnt;
  logic         w_dec;

  assign cnt_o  = r_cnt;
  assign zero_o = (r_cnt == '0);
  assign sat_o  = &r_cnt;
  // A write-back with nothing pending is legal; it must not wrap the count.
  assign w_dec  = dec && !zero_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !w_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec && !inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/arm_regfile_sb.sv
// ID-stage register file with same-cycle write-back bypass and a per-register
// pending-write scoreboard feeding hazard detection.
module arm_regfile_sb
  import arm_pkg::*;
#(
  parameter int DATA_W   = ARM_DATA_W,
  parameter int NUM_REGS = ARM_NUM_GPR,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2,
  parameter int INIT_IDX = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_dest,
  output logic                     iss_ready,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush
);

  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LP_NREGS);
  endfunction

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [PEND_W-1:0] w_cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] w_sat;
  logic [NUM_REGS-1:0] w_zero;

  logic w_wb_in;
  logic w_iss_in;
  logic w_wb_iss;
  logic w_iss_acc;

  assign w_wb_in  = wb_en && in_range(wb_addr);
  assign w_iss_in = in_range(iss_dest);
  assign w_wb_iss = w_wb_in && (wb_addr == iss_dest);

  // Issue handshake: an issue transfers on a cycle where iss_valid && iss_ready;
  // iss_ready drops only when iss_dest's counter is saturated and not retiring
  // this cycle, and the issuer must then hold iss_valid/iss_dest stable.
  assign iss_ready = !w_iss_in || !w_sat[iss_dest] || w_wb_iss;
  assign w_iss_acc = iss_valid && iss_ready && w_iss_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
      end
    end else if (w_wb_in) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.W(PEND_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (w_iss_acc && (iss_dest == ADDR_W'(r))),
      .dec    (w_wb_in && (wb_addr == ADDR_W'(r))),
      .clr    (flush),
      .cnt_o  (w_cnt[r]),
      .sat_o  (w_sat[r]),
      .zero_o (w_zero[r])
    );
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_in;
    logic              w_byp;

    assign w_a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_in  = in_range(w_a);
    assign w_byp = w_wb_in && (wb_addr == w_a);

    assign rd_data[k*DATA_W +: DATA_W] = !w_in ? '0 : (w_byp ? wb_data : r_regs[w_a]);
    // The last pending write retiring now is covered by the bypass: no stall.
    assign rd_busy[k] = w_in && !w_zero[w_a] && !(w_byp && (w_cnt[w_a] == PEND_W'(1)));
  end

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Directed bench for arm_regfile_sb: driver pushes hand-computed expectations,
// a negedge monitor pops and compares against the combinational outputs.
module tb_arm_regfile_sb;

  localparam int EXP_W = 2*32 + 2 + 1;

  logic        clk;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [3:0]  iss_dest;
  logic        iss_ready;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_cmp;
  int               n_err;

  arm_regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .iss_ready (iss_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one step = inputs applied for one cycle + the expected outputs in that cycle
  task automatic step(input logic r, input logic [3:0] a0, input logic [3:0] a1,
                      input logic iv, input logic [3:0] id,
                      input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic fl,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input logic er, input string nm);
    @(posedge clk);
    #1;
    rst       = r;
    rd_addr   = {a1, a0};
    iss_valid = iv;
    iss_dest  = id;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
    flush     = fl;
    exp_q.push_back({e1, e0, eb, er});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      string            nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if ({rd_data, rd_busy, iss_ready} !== e) begin
        n_err++;
        $display("FAIL %s: got data=%h busy=%b rdy=%b, expected data=%h busy=%b rdy=%b",
                 nm, rd_data, rd_busy, iss_ready, e[EXP_W-1:3], e[2:1], e[0]);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; rd_addr = '0; iss_valid = 1'b0; iss_dest = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);

    // reset contents, no busy, ready
    for (int i = 0; i < 15; i++) begin
      step(0, 4'(i), 4'(14-i), 0, 0, 0, 0, 0, 0, 32'(i), 32'(14-i), 2'b00, 1, "reset_read");
    end
    step(0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, "oor_read");

    // write with same-cycle bypass
    step(0, 2, 3, 0, 0, 1, 3, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 2'b00, 1, "bypass_r3");
    step(0, 3, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 2'b00, 1, "stored_r3");

    // two issues to R5, then two write-backs
    step(0, 5, 5, 1, 5, 0, 0, 0, 0, 5, 5, 2'b00, 1, "r5_iss1");
    step(0, 5, 5, 1, 5, 0, 0, 0, 0, 5, 5, 2'b11, 1, "r5_iss2");
    step(0, 5, 5, 0, 5, 0, 0, 0, 0, 5, 5, 2'b11, 1, "r5_cnt2");
    step(0, 5, 5, 0, 5, 1, 5, 32'h100, 0, 32'h100, 32'h100, 2'b11, 1, "r5_wb1");
    step(0, 5, 5, 0, 5, 1, 5, 32'h200, 0, 32'h200, 32'h200, 2'b00, 1, "r5_wb2_retire");
    step(0, 5, 5, 0, 5, 0, 0, 0, 0, 32'h200, 32'h200, 2'b00, 1, "r5_idle");

    // saturate R7
    step(0, 7, 0, 1, 7, 0, 0, 0, 0, 7, 0, 2'b00, 1, "r7_iss1");
    step(0, 7, 0, 1, 7, 0, 0, 0, 0, 7, 0, 2'b01, 1, "r7_iss2");
    step(0, 7, 0, 1, 7, 0, 0, 0, 0, 7, 0, 2'b01, 1, "r7_iss3");
    step(0, 7, 0, 1, 7, 0, 0, 0, 0, 7, 0, 2'b01, 0, "r7_iss4_blocked");
    step(0, 7, 0, 1, 7, 0, 0, 0, 0, 7, 0, 2'b01, 0, "r7_iss5_blocked");
    step(0, 7, 0, 1, 7, 1, 7, 32'h77, 0, 32'h77, 0, 2'b01, 1, "r7_iss_wb");
    step(0, 7, 0, 0, 7, 0, 0, 0, 0, 32'h77, 0, 2'b01, 0, "r7_still_sat");

    // issues then flush with a same-cycle issue
    step(0, 2, 4, 1, 2, 0, 0, 0, 0, 2, 4, 2'b00, 1, "iss_r2");
    step(0, 2, 4, 1, 4, 0, 0, 0, 0, 2, 4, 2'b01, 1, "iss_r4");
    step(0, 2, 4, 1, 9, 0, 0, 0, 1, 2, 4, 2'b11, 1, "flush_iss_r9");
    step(0, 9, 7, 0, 9, 0, 0, 0, 0, 9, 32'h77, 2'b00, 1, "post_flush_r9_r7");
    step(0, 2, 4, 0, 7, 0, 0, 0, 0, 2, 4, 2'b00, 1, "post_flush_r2_r4");

    // reset mid-stream
    step(0, 1, 0, 0, 0, 1, 1, 32'h55, 0, 32'h55, 0, 2'b00, 1, "wb_r1");
    step(0, 1, 6, 1, 6, 0, 0, 0, 0, 32'h55, 6, 2'b00, 1, "r1_iss_r6");
    step(0, 1, 6, 0, 6, 0, 0, 0, 0, 32'h55, 6, 2'b10, 1, "r6_busy");
    step(1, 1, 6, 0, 6, 0, 0, 0, 0, 1, 6, 2'b00, 1, "rst_async");
    step(0, 1, 3, 0, 6, 0, 0, 0, 0, 1, 3, 2'b00, 1, "after_rst");
    step(0, 5, 7, 0, 7, 0, 0, 0, 0, 5, 7, 2'b00, 1, "after_rst_r5_r7");

    // out-of-range write-back and issue
    step(0, 15, 14, 1, 15, 1, 15, 32'hFFFFFFFF, 0, 0, 14, 2'b00, 1, "oor_wb");
    step(0, 14, 0, 0, 15, 0, 0, 0, 0, 14, 0, 2'b00, 1, "oor_no_change");

    @(posedge clk);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
